btn_debounce: RTL and testbench

// Conditions raw Arty push-button inputs before they reach the read-only button CSR and the n_clic.
// Per-button synchronizer, debounce counter and edge detector.

---
 rtl/btn_debounce_if.sv | 25 ++
 rtl/btn_debounce.sv | 145 ++++++++++++++
 tb/tb_btn_debounce.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/btn_debounce_if.sv
// Button conditioner bus: raw pins and per-button controls in, debounced
// levels, edge pulses and interrupt-pending flags out.
interface btn_debounce_if #(
  parameter int BtnWidth = 4
);
  logic [BtnWidth-1:0] btn_in;
  logic [BtnWidth-1:0] rise_en;
  logic [BtnWidth-1:0] fall_en;
  logic [BtnWidth-1:0] pend_clear;
  logic [BtnWidth-1:0] btn_out;
  logic [BtnWidth-1:0] rise_pulse;
  logic [BtnWidth-1:0] fall_pulse;
  logic [BtnWidth-1:0] pending;
  logic                irq_any;

  modport master (
    output btn_in, rise_en, fall_en, pend_clear,
    input  btn_out, rise_pulse, fall_pulse, pending, irq_any
  );

  modport slave (
    input  btn_in, rise_en, fall_en, pend_clear,
    output btn_out, rise_pulse, fall_pulse, pending, irq_any
  );
endinterface

// File: rtl/btn_debounce.sv
// Per-button synchronizer, debounce FSM and edge detector producing clean
// levels, one-cycle edge pulses and sticky pending interrupt requests.
module btn_debounce #(
  parameter int BtnWidth       = 4,
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 20000
) (
  input logic            clk,
  input logic            reset,
  btn_debounce_if.slave  bus
);

  localparam int CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {
    S_LOW,
    W_HIGH,
    S_HIGH,
    W_LOW
  } state_t;

  logic [BtnWidth-1:0] sync_q [SyncStages];
  logic [BtnWidth-1:0] sync_d [SyncStages];
  state_t              state_q [BtnWidth];
  state_t              state_d [BtnWidth];
  logic [CntW-1:0]     cnt_q [BtnWidth];
  logic [CntW-1:0]     cnt_d [BtnWidth];
  logic [BtnWidth-1:0] btn_q, btn_d;
  logic [BtnWidth-1:0] rise_q, rise_d;
  logic [BtnWidth-1:0] fall_q, fall_d;
  logic [BtnWidth-1:0] pend_q, pend_d;
  logic                irq_q, irq_d;
  logic [BtnWidth-1:0] s;

  always_comb begin
    sync_d[0] = bus.btn_in;
    for (int k = 1; k < SyncStages; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s = sync_q[SyncStages-1];

  // The counter tracks how long `s` has held its new value; any reversion
  // drops straight back to the stable state so bounce is timed from the last toggle.
  always_comb begin
    btn_d  = btn_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < BtnWidth; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_LOW: begin
          if (s[i]) begin
            state_d[i] = W_HIGH;
            cnt_d[i]   = CntOne;
          end
        end
        W_HIGH: begin
          if (!s[i]) begin
            state_d[i] = S_LOW;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i] = S_HIGH;
            cnt_d[i]   = '0;
            btn_d[i]   = 1'b1;
            rise_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        S_HIGH: begin
          if (!s[i]) begin
            state_d[i] = W_LOW;
            cnt_d[i]   = CntOne;
          end
        end
        W_LOW: begin
          if (s[i]) begin
            state_d[i] = S_HIGH;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i] = S_LOW;
            cnt_d[i]   = '0;
            btn_d[i]   = 1'b0;
            fall_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        default: begin
          state_d[i] = S_LOW;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // A new edge outranks a simultaneous clear so no request is ever lost.
  always_comb begin
    pend_d = (pend_q & ~bus.pend_clear) |
             (rise_d & bus.rise_en) | (fall_d & bus.fall_en);
    irq_d  = |pend_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SyncStages; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < BtnWidth; i++) begin
        state_q[i] <= S_LOW;
        cnt_q[i]   <= '0;
      end
      btn_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      for (int k = 0; k < SyncStages; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < BtnWidth; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      btn_q  <= btn_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      pend_q <= pend_d;
      irq_q  <= irq_d;
    end
  end

  assign bus.btn_out    = btn_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.pending    = pend_q;
  assign bus.irq_any    = irq_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce with SyncStages=2, DebounceCycles=4:
// vector table plus hand-written corner sequences, checked through a scoreboard queue.
module tb_btn_debounce;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  btn_debounce_if #(.BtnWidth(W)) bus ();

  btn_debounce #(
    .BtnWidth(W),
    .SyncStages(2),
    .DebounceCycles(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic [3:0] ren;
    logic [3:0] fen;
    logic [3:0] clr;
    int         n;
    logic [3:0] e_out;
    logic [3:0] e_rise;
    logic [3:0] e_fall;
    logic [3:0] e_pend;
    logic       e_irq;
  } vec_t;

  typedef struct {
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] pend;
    logic       irq;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic rst, logic [3:0] btn, logic [3:0] ren,
                              logic [3:0] fen, logic [3:0] clr, int n,
                              logic [3:0] e_out, logic [3:0] e_rise,
                              logic [3:0] e_fall, logic [3:0] e_pend,
                              logic e_irq);
    vec_t v;
    v.rst = rst; v.btn = btn; v.ren = ren; v.fen = fen; v.clr = clr; v.n = n;
    v.e_out = e_out; v.e_rise = e_rise; v.e_fall = e_fall;
    v.e_pend = e_pend; v.e_irq = e_irq;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    reset          = v.rst;
    bus.btn_in     = v.btn;
    bus.rise_en    = v.ren;
    bus.fall_en    = v.fen;
    bus.pend_clear = v.clr;
    e.out = v.e_out; e.rise = v.e_rise; e.fall = v.e_fall;
    e.pend = v.e_pend; e.irq = v.e_irq;
    sb_q.push_back(e);
  endtask

  task automatic check_output();
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard at %0t: got empty queue want entry", $time);
    end else begin
      e = sb_q.pop_front();
      cmp("btn_out", bus.btn_out, e.out);
      cmp("rise_pulse", bus.rise_pulse, e.rise);
      cmp("fall_pulse", bus.fall_pulse, e.fall);
      cmp("pending", bus.pending, e.pend);
      cmp("irq_any", {3'b000, bus.irq_any}, {3'b000, e.irq});
    end
  endtask

  // Every edge of a row is checked against the same expectation.
  task automatic run_vec(input vec_t v);
    for (int c = 0; c < v.n; c++) begin
      apply_stimulus(v);
      @(posedge clk);
      #1;
      check_output();
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.btn_in     = '0;
    bus.rise_en    = '0;
    bus.fall_en    = '0;
    bus.pend_clear = '0;

    // reset state
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
    // clean press of button 0: accepted at edge 6
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 6, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 2, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1));
    // glitch on button 1 for 3 cycles is rejected
    vecs.push_back(mk(0, 4'b0011, 4'b1111, 4'b0000, 4'b0000, 3, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b0001, 4'b1111, 4'b0000, 4'b0000, 20, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1));
    // bounce on button 2, then held: one pulse 6 edges after the last rise
    vecs.push_back(mk(0, 4'b0101, 4'b1111, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b0001, 4'b1111, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b0101, 4'b1111, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b0001, 4'b1111, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b0101, 4'b1111, 4'b0000, 4'b0000, 6, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b0101, 4'b1111, 4'b0000, 4'b0000, 1, 4'b0101, 4'b0100, 4'b0000, 4'b0101, 1));
    vecs.push_back(mk(0, 4'b0101, 4'b1111, 4'b0000, 4'b0000, 2, 4'b0101, 4'b0000, 4'b0000, 4'b0101, 1));
    // release button 0 with fall_en=0: pulse only, pending untouched
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 6, 4'b0101, 4'b0000, 4'b0000, 4'b0101, 1));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0100, 4'b0000, 4'b0001, 4'b0101, 1));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0101, 1));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 4'b0101, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0));

    foreach (vecs[i]) run_vec(vecs[i]);

    // release button 2 with fall_en=1 and a clear on the set cycle: set wins
    run_vec(mk(0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 6, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0));
    run_vec(mk(0, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 1, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 1));
    run_vec(mk(0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1));
    run_vec(mk(0, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
    run_vec(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));

    // reset at edge 4 of a button 3 press: full latency again, accepted at edge 11
    run_vec(mk(0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
    run_vec(mk(1, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
    run_vec(mk(0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 6, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
    run_vec(mk(0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 1, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1));
    run_vec(mk(0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 1, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1));

    // release button 3 and clear, then press buttons 0 and 3 together
    run_vec(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 6, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1));
    run_vec(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 1));
    run_vec(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
    run_vec(mk(0, 4'b1001, 4'b1111, 4'b0000, 4'b0000, 6, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0));
    run_vec(mk(0, 4'b1001, 4'b1111, 4'b0000, 4'b0000, 1, 4'b1001, 4'b1001, 4'b0000, 4'b1001, 1));
    run_vec(mk(0, 4'b1001, 4'b1111, 4'b0000, 4'b0000, 2, 4'b1001, 4'b0000, 4'b0000, 4'b1001, 1));

    // short low glitch on held button 0 must not produce a release
    run_vec(mk(0, 4'b1000, 4'b1111, 4'b1111, 4'b0000, 2, 4'b1001, 4'b0000, 4'b0000, 4'b1001, 1));
    run_vec(mk(0, 4'b1001, 4'b1111, 4'b1111, 4'b0000, 12, 4'b1001, 4'b0000, 4'b0000, 4'b1001, 1));

    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
